// File: rtl/writeback_stage.sv
`default_nettype none
// ============================================================================
// Module      : writeback_stage
// Description : Write-back end of the scalar/vector pipeline. Commits ALU
//               results directly and assembles single- or multi-beat load
//               data from a 32-bit memory port before driving the
//               register-file write interface.
// Revision    : 1.0 - initial release
// ============================================================================
module writeback_stage #(
  parameter int LANES  = 8,
  parameter int LANE_W = 32,
  parameter int REG_AW = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    RegWrite,
  input  logic                    WriteRegisterVec,
  input  logic                    SelWriteData,
  input  logic [REG_AW-1:0]       rd,
  input  logic [LANES*LANE_W-1:0] alu_result,
  input  logic                    mem_rvalid,
  input  logic [LANE_W-1:0]       mem_rdata,
  output logic                    WRITEREGISTER_WB,
  output logic                    WRITEREGISTERVEC_WB,
  output logic [REG_AW-1:0]       RD_WB,
  output logic [LANES*LANE_W-1:0] INPUTDATA,
  output logic                    busy,
  output logic                    err
);

  localparam int DW    = LANES * LANE_W;
  localparam int CNT_W = $clog2(LANES) + 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_GATHER = 2'd1,
    S_COMMIT = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;       // next lane to fill during a gather
  logic               kind_q, kind_d;     // 1 = vector destination
  logic [REG_AW-1:0]  rd_q, rd_d;         // destination held across a gather
  logic [DW-1:0]      gbuf_q, gbuf_d;     // partially assembled load data
  logic [REG_AW-1:0]  rdo_q, rdo_d;       // RD_WB, holds outside COMMIT
  logic [DW-1:0]      dout_q, dout_d;     // INPUTDATA, holds outside COMMIT
  logic               err_q, err_d;

  logic w_accept;
  logic w_is_vec;
  logic w_is_sc;
  logic w_last_beat;

  assign in_ready = (state_q != S_GATHER);
  assign w_accept = in_valid & in_ready;
  // Both flags set is treated as a vector write; scalar writes to r0 are dropped.
  assign w_is_vec = WriteRegisterVec;
  assign w_is_sc  = RegWrite & ~WriteRegisterVec & (rd != '0);
  assign w_last_beat = kind_q ? (cnt_q == CNT_W'(LANES - 1)) : (cnt_q == '0);

  assign busy                = (state_q == S_GATHER);
  assign WRITEREGISTER_WB    = (state_q == S_COMMIT) & ~kind_q;
  assign WRITEREGISTERVEC_WB = (state_q == S_COMMIT) &  kind_q;
  assign RD_WB               = rdo_q;
  assign INPUTDATA           = dout_q;
  assign err                 = err_q;

  // Next-state, instruction capture and beat assembly.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    kind_d  = kind_q;
    rd_d    = rd_q;
    gbuf_d  = gbuf_q;
    rdo_d   = rdo_q;
    dout_d  = dout_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE, S_COMMIT: begin
        state_d = S_IDLE;
        if (w_accept) begin
          if (RegWrite & WriteRegisterVec) begin
            err_d = 1'b1;
          end
          if (w_is_vec | w_is_sc) begin
            kind_d = w_is_vec;
            if (!SelWriteData) begin
              rdo_d   = rd;
              dout_d  = w_is_vec ? alu_result
                                 : {{(DW-LANE_W){1'b0}}, alu_result[LANE_W-1:0]};
              state_d = S_COMMIT;
            end else begin
              rd_d    = rd;
              cnt_d   = '0;
              gbuf_d  = '0;
              state_d = S_GATHER;
            end
          end
        end
      end

      S_GATHER: begin
        if (mem_rvalid) begin
          for (int i = 0; i < LANES; i++) begin
            if (cnt_q == CNT_W'(i)) begin
              gbuf_d[i*LANE_W +: LANE_W] = mem_rdata;
            end
          end
          cnt_d = cnt_q + CNT_W'(1);
          if (w_last_beat) begin
            rdo_d   = rd_q;
            dout_d  = kind_q ? gbuf_d : {{(DW-LANE_W){1'b0}}, gbuf_d[LANE_W-1:0]};
            state_d = S_COMMIT;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset clears everything including a partial gather.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      kind_q  <= 1'b0;
      rd_q    <= '0;
      gbuf_q  <= '0;
      rdo_q   <= '0;
      dout_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      kind_q  <= kind_d;
      rd_q    <= rd_d;
      gbuf_q  <= gbuf_d;
      rdo_q   <= rdo_d;
      dout_q  <= dout_d;
      err_q   <= err_d;
    end
  end

endmodule
`default_nettype wire
